// File: rtl/spi_frame_receiver.sv
// spi_frame_receiver
//   SPI mode-1 (CPOL=0, CPHA=1) slave receiver and RGBW lamp frame parser.
//   The asynchronous SPI pins are oversampled on clk12. Bits are assembled
//   MSB-first into bytes. The 8-byte frame 55 FF CMD C0 C1 C2 C3 CHK is parsed,
//   where CHK = CMD^C0^C1^C2^C3. Accepted frames are presented with a one-cycle
//   strobe.
//
// Parameters
//   TIMEOUT_CYCLES : idle clk12 cycles between bytes of a frame before abort
// Ports
//   clk12         in   system clock
//   reset         in   synchronous, active-high reset
//   sck0          in   SPI clock (async, idles low)
//   mosi          in   SPI data (async)
//   cs            in   chip select, active low (async)
//   rx_byte       out  last completed byte
//   rx_byte_valid out  1-cycle strobe, rx_byte is new
//   frame_cmd     out  CMD byte of the last accepted frame
//   frame_ch0..3  out  C0..C3 of the last accepted frame
//   frame_valid   out  1-cycle strobe, frame outputs just updated
//   frame_err     out  1-cycle strobe, checksum mismatch or inter-byte timeout
module spi_frame_receiver #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk12,
  input  logic       reset,
  input  logic       sck0,
  input  logic       mosi,
  input  logic       cs,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic [7:0] frame_cmd,
  output logic [7:0] frame_ch0,
  output logic [7:0] frame_ch1,
  output logic [7:0] frame_ch2,
  output logic [7:0] frame_ch3,
  output logic       frame_valid,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_HUNT,
    S_SYNC,
    S_CMD,
    S_DATA,
    S_CHK
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronisers. The third sck stage exists only for edge detection.
  // ---------------------------------------------------------------------------
  logic sck_s1, sck_s2, sck_s3;
  logic mosi_s1, mosi_s2;
  logic cs_s1, cs_s2;

  // NOTE: sequential state is assigned with <= so that every flop samples the
  // values from before the clock edge, whatever the statement order is.
  always_ff @(posedge clk12) begin
    if (reset) begin
      sck_s1  <= 1'b0;
      sck_s2  <= 1'b0;
      sck_s3  <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
    end else begin
      sck_s1  <= sck0;
      sck_s2  <= sck_s1;
      sck_s3  <= sck_s2;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
      cs_s1   <= cs;
      cs_s2   <= cs_s1;
    end
  end

  logic sck_fall;
  assign sck_fall = sck_s3 & ~sck_s2 & ~cs_s2;

  // ---------------------------------------------------------------------------
  // Byte assembly. Deasserting cs drops any partial byte without a strobe.
  // ---------------------------------------------------------------------------
  logic [7:0] shift_reg;
  logic [2:0] bit_cnt;

  always_ff @(posedge clk12) begin
    if (reset) begin
      shift_reg     <= '0;
      bit_cnt       <= '0;
      rx_byte       <= '0;
      rx_byte_valid <= 1'b0;
    end else begin
      rx_byte_valid <= 1'b0;
      if (cs_s2) begin
        shift_reg <= '0;
        bit_cnt   <= '0;
      end else if (sck_fall) begin
        shift_reg <= {shift_reg[6:0], mosi_s2};
        bit_cnt   <= bit_cnt + 3'd1;  // wraps to 0 after the 8th bit
        if (bit_cnt == 3'd7) begin
          rx_byte       <= {shift_reg[6:0], mosi_s2};
          rx_byte_valid <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Inter-byte idle counter, saturating at TIMEOUT_CYCLES.
  // ---------------------------------------------------------------------------
  logic [TW-1:0] idle_cnt;
  logic          timeout;

  always_ff @(posedge clk12) begin
    if (reset)                 idle_cnt <= '0;
    else if (rx_byte_valid)    idle_cnt <= '0;
    else if (idle_cnt != T_MAX) idle_cnt <= idle_cnt + 1'b1;
  end

  assign timeout = (idle_cnt == T_MAX);

  // ---------------------------------------------------------------------------
  // Frame parser
  // ---------------------------------------------------------------------------
  state_t          state, state_nxt;
  logic [1:0]      idx, idx_nxt;
  logic [7:0]      cmd_sh, cmd_sh_nxt;
  logic [3:0][7:0] ch_sh, ch_sh_nxt;
  logic [3:0][7:0] frame_ch;
  logic            ok_nxt, err_nxt;
  logic [7:0]      chk_sum;

  assign chk_sum = cmd_sh ^ ch_sh[0] ^ ch_sh[1] ^ ch_sh[2] ^ ch_sh[3];

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    cmd_sh_nxt = cmd_sh;
    ch_sh_nxt  = ch_sh;
    ok_nxt     = 1'b0;
    err_nxt    = 1'b0;
    if (rx_byte_valid) begin
      // A byte arriving in the cycle the timeout expires wins over the timeout.
      case (state)
        S_HUNT: if (rx_byte == 8'h55) state_nxt = S_SYNC;
        S_SYNC: begin
          if (rx_byte == 8'hFF)      state_nxt = S_CMD;
          else if (rx_byte != 8'h55) state_nxt = S_HUNT;
        end
        S_CMD: begin
          cmd_sh_nxt = rx_byte;
          idx_nxt    = 2'd0;
          state_nxt  = S_DATA;
        end
        S_DATA: begin
          ch_sh_nxt[idx] = rx_byte;
          idx_nxt        = idx + 2'd1;
          if (idx == 2'd3) state_nxt = S_CHK;
        end
        S_CHK: begin
          if (rx_byte == chk_sum) ok_nxt  = 1'b1;
          else                    err_nxt = 1'b1;
          state_nxt = S_HUNT;
        end
        default: state_nxt = S_HUNT;
      endcase
    end else if (timeout && state != S_HUNT) begin
      err_nxt   = 1'b1;
      state_nxt = S_HUNT;
    end
  end

  // NOTE: the shadow registers are reset along with the control state so a
  // reset mid-frame can never leak stale channel bytes into a later frame.
  always_ff @(posedge clk12) begin
    if (reset) begin
      state       <= S_HUNT;
      idx         <= '0;
      cmd_sh      <= '0;
      ch_sh       <= '0;
      frame_cmd   <= '0;
      frame_ch    <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      cmd_sh      <= cmd_sh_nxt;
      ch_sh       <= ch_sh_nxt;
      frame_valid <= ok_nxt;
      frame_err   <= err_nxt;
      if (ok_nxt) begin
        frame_cmd <= cmd_sh;
        frame_ch  <= ch_sh;
      end
    end
  end

  assign frame_ch0 = frame_ch[0];
  assign frame_ch1 = frame_ch[1];
  assign frame_ch2 = frame_ch[2];
  assign frame_ch3 = frame_ch[3];

endmodule

// File: tb/tb_spi_frame_receiver.sv
// tb_spi_frame_receiver
//   Self-checking bench for spi_frame_receiver. Stimulus tasks push expected
//   bytes and frame events into queues, using a byte-level frame model. An
//   independent monitor pops and compares whenever the DUT strobes.
module tb_spi_frame_receiver;

  localparam int TIMEOUT = 4096;

  logic       clk12 = 1'b0;
  logic       reset;
  logic       sck0, mosi, cs;
  logic [7:0] rx_byte;
  logic       rx_byte_valid;
  logic [7:0] frame_cmd, frame_ch0, frame_ch1, frame_ch2, frame_ch3;
  logic       frame_valid, frame_err;

  spi_frame_receiver #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk12        (clk12),
    .reset        (reset),
    .sck0         (sck0),
    .mosi         (mosi),
    .cs           (cs),
    .rx_byte      (rx_byte),
    .rx_byte_valid(rx_byte_valid),
    .frame_cmd    (frame_cmd),
    .frame_ch0    (frame_ch0),
    .frame_ch1    (frame_ch1),
    .frame_ch2    (frame_ch2),
    .frame_ch3    (frame_ch3),
    .frame_valid  (frame_valid),
    .frame_err    (frame_err)
  );

  always #5 clk12 = ~clk12;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a frame is whatever bytes follow a 55 FF header; the
  // header tolerates repeated 55s. Expected outputs are pushed to queues.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic        is_err;
    logic [7:0]  cmd;
    logic [31:0] ch;   // {ch0, ch1, ch2, ch3}
  } ev_t;

  logic [7:0]  exp_bytes[$];
  ev_t         exp_ev[$];
  logic [7:0]  hist[$];
  logic [7:0]  last_cmd = 8'h00;
  logic [31:0] last_ch  = 32'h0;

  task automatic model_byte(input logic [7:0] b);
    logic [7:0] x;
    ev_t        e;
    exp_bytes.push_back(b);
    if (hist.size() == 0) begin
      if (b == 8'h55) hist.push_back(b);
    end else if (hist.size() == 1) begin
      if (b == 8'hFF)      hist.push_back(b);
      else if (b != 8'h55) hist.delete();
    end else begin
      hist.push_back(b);
      if (hist.size() == 8) begin
        x = hist[2] ^ hist[3] ^ hist[4] ^ hist[5] ^ hist[6];
        if (x == hist[7]) begin
          last_cmd = hist[2];
          last_ch  = {hist[3], hist[4], hist[5], hist[6]};
          e.is_err = 1'b0;
        end else begin
          e.is_err = 1'b1;
        end
        e.cmd = last_cmd;
        e.ch  = last_ch;
        exp_ev.push_back(e);
        hist.delete();
      end
    end
  endtask

  // The bench is about to idle past the timeout: an open frame aborts.
  task automatic model_timeout();
    ev_t e;
    if (hist.size() != 0) begin
      e.is_err = 1'b1;
      e.cmd    = last_cmd;
      e.ch     = last_ch;
      exp_ev.push_back(e);
      hist.delete();
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  logic prev_rbv = 1'b0, prev_fv = 1'b0, prev_fe = 1'b0;

  always @(negedge clk12) begin
    if (reset !== 1'b1) begin
      if (rx_byte_valid === 1'b1) begin
        check("rx_byte_valid_width", {39'd0, prev_rbv}, 40'd0);
        if (exp_bytes.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_byte: got %h, expected no byte", rx_byte);
        end else begin
          check("rx_byte", {32'd0, rx_byte}, {32'd0, exp_bytes.pop_front()});
        end
      end
      if (frame_valid === 1'b1 || frame_err === 1'b1) begin
        ev_t e;
        check("strobe_exclusive", {39'd0, frame_valid & frame_err}, 40'd0);
        check("frame_strobe_width", {38'd0, prev_fv, prev_fe}, 40'd0);
        if (exp_ev.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_frame_event: got valid=%b err=%b, expected none",
                   frame_valid, frame_err);
        end else begin
          e = exp_ev.pop_front();
          check("frame_event_kind", {39'd0, frame_err}, {39'd0, e.is_err});
          check("frame_cmd", {32'd0, frame_cmd}, {32'd0, e.cmd});
          check("frame_ch", {8'd0, frame_ch0, frame_ch1, frame_ch2, frame_ch3}, {8'd0, e.ch});
        end
      end
    end
    prev_rbv = (rx_byte_valid === 1'b1);
    prev_fv  = (frame_valid === 1'b1);
    prev_fe  = (frame_err === 1'b1);
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change on the falling clk12 edge)
  // ---------------------------------------------------------------------------
  logic [7:0] seq[$];

  task automatic idle(input int n);
    repeat (n) @(negedge clk12);
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits, input int hp, input bit raise);
    if (cs) begin
      cs = 1'b0;
      idle(4);
    end
    for (int i = 0; i < nbits; i++) begin
      sck0 = 1'b1;
      mosi = b[7-i];
      idle(hp);
      sck0 = 1'b0;
      idle(hp);
    end
    if (raise) begin
      idle(hp);
      cs = 1'b1;
      idle(6);
    end
  endtask

  task automatic send_seq(input bit per_byte_cs, input int hp);
    for (int i = 0; i < seq.size(); i++) begin
      model_byte(seq[i]);
      send_bits(seq[i], 8, hp, per_byte_cs || (i == seq.size() - 1));
    end
  endtask

  task automatic drain(input string name);
    idle(20);
    check({name, "_bytes_drained"}, 40'(exp_bytes.size()), 40'd0);
    check({name, "_events_drained"}, 40'(exp_ev.size()), 40'd0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_rx"}, {31'd0, rx_byte_valid, rx_byte}, 40'd0);
    check({name, "_frame"}, {frame_cmd, frame_ch0, frame_ch1, frame_ch2, frame_ch3}, 40'd0);
    check({name, "_strobes"}, {38'd0, frame_valid, frame_err}, 40'd0);
  endtask

  task automatic do_reset();
    @(negedge clk12);
    reset = 1'b1;
    hist.delete();
    last_cmd = 8'h00;
    last_ch  = 32'h0;
    @(negedge clk12);
    check_all_zero("after_reset");
    reset = 1'b0;
  endtask

  // Watchdog: the whole run is bounded.
  initial begin
    repeat (95000) @(posedge clk12);
    $display("FAIL watchdog: got run still active, expected completion; errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b1;
    sck0  = 1'b0;
    mosi  = 1'b0;
    cs    = 1'b1;
    idle(3);
    check_all_zero("initial_reset");
    reset = 1'b0;
    idle(5);

    // Valid frame, one CS assertion per byte.
    seq = '{8'h55, 8'hFF, 8'h24, 8'h00, 8'hFF, 8'h00, 8'hAA, 8'h71};
    send_seq(1'b1, 16);
    drain("frame1");

    // Same frame with a bad checksum: error, outputs hold.
    seq = '{8'h55, 8'hFF, 8'h24, 8'h00, 8'hFF, 8'h00, 8'hAA, 8'hA4};
    send_seq(1'b1, 16);
    drain("bad_chk");
    check("hold_after_err", {frame_cmd, frame_ch0, frame_ch1, frame_ch2, frame_ch3},
          40'h2400FF00AA);

    // Junk byte and repeated sync in one CS assertion.
    seq = '{8'hAA, 8'h55, 8'h55, 8'hFF, 8'h23, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hDC};
    send_seq(1'b0, 16);
    drain("resync");

    // Timeout mid-frame, then a complete frame.
    seq = '{8'h55, 8'hFF, 8'h24};
    send_seq(1'b1, 16);
    model_timeout();
    idle(TIMEOUT + 10);
    check("timeout_fired", 40'(exp_ev.size()), 40'd0);
    seq = '{8'h55, 8'hFF, 8'h24, 8'h00, 8'hFF, 8'h00, 8'hAA, 8'h71};
    send_seq(1'b1, 16);
    drain("after_timeout");

    // A long gap that stays under the timeout does not abort the frame.
    seq = '{8'h55, 8'hFF, 8'h11};
    send_seq(1'b1, 16);
    idle(TIMEOUT - 600);
    seq = '{8'h22, 8'h33, 8'h44, 8'h55, 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44 ^ 8'h55};
    send_seq(1'b1, 16);
    drain("long_gap");

    // Partial byte discarded by CS deassertion.
    send_bits(8'h55, 4, 16, 1'b1);
    seq = '{8'h55, 8'hFF, 8'hA0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h5F};
    send_seq(1'b1, 16);
    drain("partial");

    // Reset after C1: the remainder of the frame must not be accepted.
    seq = '{8'h55, 8'hFF, 8'h24, 8'h00, 8'hFF};
    send_seq(1'b1, 16);
    drain("pre_reset");
    do_reset();
    seq = '{8'h00, 8'hAA, 8'h71};
    send_seq(1'b1, 16);
    drain("post_reset");
    check("post_reset_frame", {frame_cmd, frame_ch0, frame_ch1, frame_ch2, frame_ch3}, 40'd0);

    // Randomized frames, corruptions, junk and partial bytes.
    for (int n = 0; n < 16; n++) begin
      int         kind;
      int         hp;
      logic [7:0] c0, c1, c2, c3, cm, ck;
      kind = $urandom_range(0, 9);
      hp   = $urandom_range(6, 12);
      cm = 8'($urandom); c0 = 8'($urandom); c1 = 8'($urandom);
      c2 = 8'($urandom); c3 = 8'($urandom);
      ck = cm ^ c0 ^ c1 ^ c2 ^ c3;
      if (kind == 7) ck = ck ^ 8'(1 << $urandom_range(0, 7));
      if (kind == 8) begin
        seq = '{8'($urandom)};
        send_seq(1'b1, hp);
      end else if (kind == 9) begin
        send_bits(8'($urandom), $urandom_range(1, 7), hp, 1'b1);
      end else begin
        seq = '{8'h55, 8'hFF, cm, c0, c1, c2, c3, ck};
        send_seq(1'($urandom_range(0, 1)), hp);
      end
      idle($urandom_range(2, 40));
    end
    drain("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
